// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clock divider with start/stop sequencing and boundary-aligned ratio changes (optional tick counter: CLK_DIV_TICK_CNT_EN)
module clk_div_ctrl #(
    parameter int SEL_W   = 3,
    parameter int CNT_W   = 8,
    parameter int RST_SEL = 2,
    parameter int TCNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_valid,
    input  logic [SEL_W-1:0]  cfg_sel,
    output logic              cfg_ready,
    output logic              div_clk,
    output logic              tick,
    output logic              busy,
`ifdef CLK_DIV_TICK_CNT_EN
    output logic [TCNT_W-1:0] tick_count,
`endif
    output logic [SEL_W-1:0]  cur_sel
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [SEL_W-1:0] SEL_RST = SEL_W'(RST_SEL);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
    logic               pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]   period_last;
    logic               running;
    logic               tick_w;
    logic               cfg_xfer;

    // Terminal count P-1 = 2^(sel+1)-1, i.e. bits [cur_sel:0] set
    always_comb begin
        period_last = '0;
        for (int i = 0; i < CNT_W; i++) begin
            period_last[i] = (i <= int'(cur_sel_q));
        end
    end

    // Outputs are decoded purely from registered state, so no input reaches them combinationally
    always_comb begin
        running   = (state_q != ST_IDLE);
        tick_w    = running && (cnt_q == period_last);
        cfg_ready = (state_q == ST_IDLE) || ((state_q == ST_RUN) && !pend_valid_q);
        cfg_xfer  = cfg_valid && cfg_ready;
        busy      = running;
        tick      = tick_w;
        div_clk   = cnt_q[cur_sel_q];
        cur_sel   = cur_sel_q;
    end

    // Next-state logic: ratio changes and stops only land on the tick cycle
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_sel_d    = cur_sel_q;
        pend_sel_d   = pend_sel_q;
        pend_valid_d = pend_valid_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d        = '0;
                pend_valid_d = 1'b0;
                // A config offered together with start shapes the very first period
                if (cfg_xfer) begin
                    cur_sel_d = cfg_sel;
                end
                if (start && !stop) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                cnt_d = tick_w ? '0 : (cnt_q + CNT_ONE);
                if (tick_w && pend_valid_q) begin
                    cur_sel_d    = pend_sel_q;
                    pend_valid_d = 1'b0;
                end
                // cfg_xfer implies pend_valid_q==0, so this never collides with the apply above
                if (cfg_xfer) begin
                    pend_sel_d   = cfg_sel;
                    pend_valid_d = 1'b1;
                end
                if (stop) begin
                    if (tick_w) begin
                        // Stop lands on a boundary: finish now, and a config accepted
                        // on this same edge takes effect as the stop completes
                        state_d      = ST_IDLE;
                        cnt_d        = '0;
                        pend_valid_d = 1'b0;
                        if (cfg_xfer) begin
                            cur_sel_d = cfg_sel;
                        end
                    end else begin
                        state_d = ST_STOP_PEND;
                    end
                end
            end

            ST_STOP_PEND: begin
                cnt_d = tick_w ? '0 : (cnt_q + CNT_ONE);
                if (tick_w) begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    pend_valid_d = 1'b0;
                    if (pend_valid_q) begin
                        cur_sel_d = pend_sel_q;
                    end
                end
            end

            default: begin
                state_d      = ST_IDLE;
                cnt_d        = '0;
                pend_valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset also drops any pending config
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cur_sel_q    <= SEL_RST;
            pend_sel_q   <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_sel_q    <= cur_sel_d;
            pend_sel_q   <= pend_sel_d;
            pend_valid_q <= pend_valid_d;
        end
    end

`ifdef CLK_DIV_TICK_CNT_EN
    localparam logic [TCNT_W-1:0] TCNT_ONE = TCNT_W'(1);
    logic [TCNT_W-1:0] tcnt_q;

    // Tick counter: cleared when a run begins, counts every tick, holds while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
        end else if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
            tcnt_q <= '0;
        end else if (tick_w) begin
            tcnt_q <= tcnt_q + TCNT_ONE;
        end
    end

    assign tick_count = tcnt_q;
`else
    logic [TCNT_W-1:0] unused_tcnt;
    assign unused_tcnt = '0;
`endif

endmodule
